// File: rtl/axi_to_mem_pkg.sv
// Shared types for the AXI-to-memory path: burst encodings, sequencer state,
// response metadata and burst descriptor layouts.
package axi_to_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_ID_WIDTH   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0] id;
        logic                    last;
        logic                    write;
    } meta_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      write;
    } cmd_t;

    // AXI only defines WRAP for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_mem_burst_seq_if.sv
// Burst descriptor, write beat, memory request and metadata signals of the
// burst sequencer; slave is the sequencer side, master the environment side.
interface axi_mem_burst_seq_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [IdWidth-1:0]   cmd_id;
    logic [AddrWidth-1:0] cmd_addr;
    logic [7:0]           cmd_len;
    logic [2:0]           cmd_size;
    logic [1:0]           cmd_burst;
    logic                 cmd_write;

    logic                 w_valid;
    logic                 w_ready;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;

    logic                 mem_req;
    logic                 mem_gnt;
    logic [AddrWidth-1:0] mem_addr;
    logic                 mem_we;
    logic [DataWidth-1:0] mem_wdata;
    logic [StrbWidth-1:0] mem_strb;

    logic                 meta_valid;
    logic                 meta_ready;
    logic [IdWidth-1:0]   meta_id;
    logic                 meta_last;
    logic                 meta_write;

    logic                 busy;

    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_write,
        output cmd_ready,
        input  w_valid, w_data, w_strb,
        output w_ready,
        output mem_req, mem_addr, mem_we, mem_wdata, mem_strb,
        input  mem_gnt,
        output meta_valid, meta_id, meta_last, meta_write,
        input  meta_ready,
        output busy
    );

    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_write,
        input  cmd_ready,
        output w_valid, w_data, w_strb,
        input  w_ready,
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_strb,
        output mem_gnt,
        input  meta_valid, meta_id, meta_last, meta_write,
        output meta_ready,
        input  busy
    );

endinterface

// File: rtl/axi_burst_next_addr.sv
// Next beat address for an AXI burst (FIXED / INCR / WRAP).
// Purely combinational, zero latency; no handshake.
module axi_burst_next_addr
    import axi_to_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = DEF_ADDR_WIDTH
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [2:0]           size,
    input  logic [7:0]           len,
    input  logic [1:0]           burst,
    output logic [AddrWidth-1:0] next_addr
);

    logic [AddrWidth-1:0] beat_bytes;
    logic [AddrWidth-1:0] incr_addr;
    logic [AddrWidth-1:0] wrap_mask;

    always_comb begin
        beat_bytes = AddrWidth'(1) << size;
        incr_addr  = (addr & ~(beat_bytes - AddrWidth'(1))) + beat_bytes;
        wrap_mask  = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
        next_addr  = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            // Illegal WRAP lengths fall back to INCR, as does the reserved encoding.
            BURST_WRAP:  if (wrap_len_ok(len)) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_burst_seq.sv
// Splits one AXI burst at a time into single-beat memory requests plus metadata.
// Latency: first request one cycle after descriptor accept, then one beat per grant.
// Backpressure: no request while metadata queue full or write data missing; state held.
module axi_mem_burst_seq
    import axi_to_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = DEF_ADDR_WIDTH,
    parameter int unsigned DataWidth = DEF_DATA_WIDTH,
    parameter int unsigned IdWidth   = DEF_ID_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    axi_mem_burst_seq_if.slave bus
);

    localparam int unsigned          StrbWidth = DataWidth / 8;
    localparam logic [StrbWidth-1:0] StrbAll   = '1;

    seq_state_e           state;
    logic [IdWidth-1:0]   id_q;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           cnt_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic                 write_q;

    logic [AddrWidth-1:0] addr_nxt;
    logic                 in_burst;
    logic                 req;
    logic                 beat;
    logic                 last_beat;
    logic                 cmd_hs;

    axi_burst_next_addr #(.AddrWidth(AddrWidth)) u_next_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    // Request only when the beat can fully complete, so it never depends on the grant.
    assign in_burst  = (state == ST_BURST);
    assign req       = in_burst & bus.meta_ready & (~write_q | bus.w_valid);
    assign beat      = req & bus.mem_gnt;
    assign last_beat = (cnt_q == len_q);
    assign cmd_hs    = bus.cmd_valid & bus.cmd_ready;

    assign bus.cmd_ready  = ~in_burst | (beat & last_beat);
    assign bus.w_ready    = beat & write_q;
    assign bus.mem_req    = req;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = write_q;
    assign bus.mem_wdata  = bus.w_data;
    assign bus.mem_strb   = write_q ? bus.w_strb : StrbAll;
    assign bus.meta_valid = beat;
    assign bus.meta_id    = id_q;
    assign bus.meta_last  = last_beat;
    assign bus.meta_write = write_q;
    assign bus.busy       = in_burst;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            write_q <= 1'b0;
        end else if (cmd_hs) begin
            // Also covers the reload on the last granted beat of the previous burst.
            state   <= ST_BURST;
            id_q    <= bus.cmd_id;
            addr_q  <= bus.cmd_addr;
            cnt_q   <= 8'd0;
            len_q   <= bus.cmd_len;
            size_q  <= bus.cmd_size;
            burst_q <= bus.cmd_burst;
            write_q <= bus.cmd_write;
        end else if (beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_nxt;
            if (last_beat) state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_axi_mem_burst_seq.sv
// Bench for axi_mem_burst_seq: directed scenarios plus randomized traffic,
// all checked each cycle against a beat-list model of the AXI address rules.
module tb_axi_mem_burst_seq;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          last;
        logic          write;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_burst_seq_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

    axi_mem_burst_seq #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    bit acc    = 1'b0;

    beat_t         exq[$];
    logic [AW-1:0] glog[$];
    logic          llog[$];
    logic          crlog[$];
    logic          wrlog[$];
    int            cyclog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expands a descriptor into its beat list using the AXI address formulas.
    function automatic void push_burst(input logic [IW-1:0] id, input logic [AW-1:0] a,
                                       input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input logic wr);
        longint unsigned bytes, total, aligned, lower, x;
        bit    wrap;
        beat_t b;
        bytes   = 64'd1 << size;
        total   = (longint'(len) + 1) * bytes;
        aligned = longint'(a) - (longint'(a) % bytes);
        lower   = aligned - (aligned % total);
        wrap    = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == 0 || burst == 2'b00) x = longint'(a);
            else if (wrap)                x = lower + ((aligned - lower + longint'(i) * bytes) % total);
            else                          x = aligned + longint'(i) * bytes;
            b.addr  = x[AW-1:0];
            b.id    = id;
            b.last  = (i == int'(len));
            b.write = wr;
            exq.push_back(b);
        end
    endfunction

    // One cycle: inputs were set after the previous negedge; check, update model, advance.
    task automatic tick();
        logic  exp_req, exp_beat, exp_cready, has;
        beat_t f;
        #1;
        has = (exq.size() > 0);
        f   = has ? exq[0] : '0;
        exp_req    = has && bus.meta_ready && (!f.write || bus.w_valid);
        exp_beat   = exp_req && bus.mem_gnt;
        exp_cready = !has || (exp_beat && f.last);
        chk("cmd_ready",  bus.cmd_ready,  exp_cready);
        chk("mem_req",    bus.mem_req,    exp_req);
        chk("busy",       bus.busy,       has);
        chk("meta_valid", bus.meta_valid, exp_beat);
        chk("w_ready",    bus.w_ready,    exp_beat && f.write);
        if (has) chk("mem_addr", bus.mem_addr, f.addr);
        if (exp_req) begin
            chk("mem_we",    bus.mem_we,    f.write);
            chk("mem_strb",  bus.mem_strb,  f.write ? bus.w_strb : {SW{1'b1}});
            chk("mem_wdata", bus.mem_wdata, bus.w_data);
        end
        if (exp_beat) begin
            chk("meta_id",    bus.meta_id,    f.id);
            chk("meta_last",  bus.meta_last,  f.last);
            chk("meta_write", bus.meta_write, f.write);
            glog.push_back(bus.mem_addr);
            llog.push_back(bus.meta_last);
            crlog.push_back(bus.cmd_ready);
            wrlog.push_back(bus.w_ready);
            cyclog.push_back(cyc);
            void'(exq.pop_front());
        end
        acc = 1'b0;
        if (!rst_n) exq.delete();
        else if (bus.cmd_valid && exp_cready) begin
            acc = 1'b1;
            push_burst(bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst, bus.cmd_write);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic wr);
        bus.cmd_valid = 1'b1;
        bus.cmd_id    = id;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        bus.cmd_size  = size;
        bus.cmd_burst = burst;
        bus.cmd_write = wr;
    endtask

    task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input logic wr);
        int n;
        set_cmd(id, a, len, size, burst, wr);
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("cmd_accept_timeout", 64'(n), 64'd0);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic clear_logs();
        glog.delete(); llog.delete(); crlog.delete(); wrlog.delete(); cyclog.delete();
    endtask

    task automatic new_cmd();
        int r;
        r = $urandom_range(0, 9);
        bus.cmd_id    = IW'($urandom);
        bus.cmd_addr  = (r == 9) ? 32'hFFFF_FFF0 : AW'($urandom);
        if (r < 4)      bus.cmd_len = 8'($urandom_range(0, 3));
        else if (r < 8) bus.cmd_len = 8'((1 << $urandom_range(1, 4)) - 1);
        else            bus.cmd_len = 8'($urandom_range(0, 40));
        bus.cmd_size  = 3'($urandom_range(0, 3));
        bus.cmd_burst = 2'($urandom_range(0, 3));
        bus.cmd_write = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int n, wcount;
        logic [AW-1:0] exp_a[$];
        bus.cmd_valid = 0; bus.cmd_id = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
        bus.cmd_size = 0; bus.cmd_burst = 0; bus.cmd_write = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0;
        bus.mem_gnt = 0; bus.meta_ready = 0;

        // Reset state
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        bus.meta_ready = 1; bus.mem_gnt = 1;

        // INCR read 0x100, len 3, size 3
        clear_logs();
        send(4'h3, 32'h100, 8'd3, 3'd3, 2'b01, 1'b0);
        exp_a = '{32'h100, 32'h108, 32'h110, 32'h118};
        chk("model_incr_n", 64'(exq.size()), 64'd4);
        for (int i = 0; i < 4; i++) if (i < exq.size()) chk("model_incr_addr", exq[i].addr, exp_a[i]);
        repeat (4) tick();
        chk("incr_nbeats", 64'(glog.size()), 64'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk("incr_addr", glog[i], exp_a[i]);
            chk("incr_last", llog[i], (i == 3));
            chk("incr_cready", crlog[i], (i == 3));
        end

        // WRAP write 0x38, len 3, size 3
        clear_logs();
        bus.w_valid = 1; bus.w_data = 64'hDEAD_BEEF_0123_4567; bus.w_strb = 8'hA5;
        send(4'h9, 32'h38, 8'd3, 3'd3, 2'b10, 1'b1);
        exp_a = '{32'h38, 32'h20, 32'h28, 32'h30};
        for (int i = 0; i < 4; i++) if (i < exq.size()) chk("model_wrap_addr", exq[i].addr, exp_a[i]);
        repeat (4) tick();
        wcount = 0;
        foreach (wrlog[i]) wcount += int'(wrlog[i]);
        chk("wrap_wready_cnt", 64'(wcount), 64'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("wrap_addr", glog[i], exp_a[i]);

        // FIXED len 0 followed back-to-back by INCR len 1
        clear_logs();
        bus.w_valid = 0;
        set_cmd(4'h5, 32'h2004, 8'd0, 3'd2, 2'b00, 1'b0);
        tick();
        set_cmd(4'h6, 32'h300, 8'd1, 3'd3, 2'b01, 1'b0);
        tick();
        chk("b2b_accept", 64'(acc), 64'd1);
        bus.cmd_valid = 0;
        repeat (2) tick();
        exp_a = '{32'h2004, 32'h300, 32'h308};
        chk("b2b_nbeats", 64'(glog.size()), 64'd3);
        for (int i = 0; i < 3 && i < glog.size(); i++) chk("b2b_addr", glog[i], exp_a[i]);
        if (cyclog.size() == 3) begin
            chk("b2b_gap0", 64'(cyclog[1] - cyclog[0]), 64'd1);
            chk("b2b_gap1", 64'(cyclog[2] - cyclog[1]), 64'd1);
            chk("fixed_last", llog[0], 1'b1);
        end

        // Metadata and write-data backpressure mid-burst
        clear_logs();
        bus.w_valid = 1;
        send(4'h2, 32'h1000, 8'd5, 3'd2, 2'b01, 1'b1);
        repeat (2) tick();
        bus.meta_ready = 0;
        repeat (3) begin
            tick();
            chk("stall_meta_addr", bus.mem_addr, 32'h1008);
            chk("stall_meta_req", bus.mem_req, 1'b0);
        end
        bus.meta_ready = 1; bus.w_valid = 0;
        repeat (2) begin
            tick();
            chk("stall_w_addr", bus.mem_addr, 32'h1008);
            chk("stall_w_req", bus.mem_req, 1'b0);
        end
        bus.w_valid = 1;
        repeat (4) tick();
        chk("bp_nbeats", 64'(glog.size()), 64'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("bp_addr", glog[i], 32'h1000 + 32'(4 * i));

        // Grant stall
        clear_logs();
        bus.w_valid = 0; bus.mem_gnt = 0;
        send(4'h1, 32'h2000, 8'd2, 3'd3, 2'b01, 1'b0);
        repeat (2) begin
            #1;
            chk("gstall_req", bus.mem_req, 1'b1);
            chk("gstall_meta", bus.meta_valid, 1'b0);
            chk("gstall_addr", bus.mem_addr, 32'h2000);
            tick();
        end
        bus.mem_gnt = 1;
        repeat (3) tick();
        exp_a = '{32'h2000, 32'h2008, 32'h2010};
        chk("gstall_nbeats", 64'(glog.size()), 64'd3);
        for (int i = 0; i < 3 && i < glog.size(); i++) chk("gstall_post", glog[i], exp_a[i]);

        // Reset on the second beat of a len 7 burst
        clear_logs();
        send(4'h7, 32'h4000, 8'd7, 3'd3, 2'b01, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_cready", bus.cmd_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        exq.delete();
        tick();
        rst_n = 1'b1;
        clear_logs();
        send(4'h8, 32'h5000, 8'd1, 3'd2, 2'b01, 1'b0);
        repeat (2) tick();
        chk("post_rst_n", 64'(glog.size()), 64'd2);
        for (int i = 0; i < 2 && i < glog.size(); i++) chk("post_rst_addr", glog[i], 32'h5000 + 32'(4 * i));

        // Randomized traffic
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.cmd_valid || acc) begin
                bus.cmd_valid = ($urandom_range(0, 3) != 0);
                if (bus.cmd_valid) new_cmd();
            end
            bus.meta_ready = ($urandom_range(0, 9) < 8);
            bus.w_valid    = ($urandom_range(0, 3) != 0);
            bus.mem_gnt    = ($urandom_range(0, 9) < 7);
            bus.w_data     = {$urandom, $urandom};
            bus.w_strb     = SW'($urandom);
            tick();
        end
        bus.cmd_valid = 0; bus.meta_ready = 1; bus.w_valid = 1; bus.mem_gnt = 1;
        n = 0;
        while (exq.size() > 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(exq.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
